// File: rtl/pc_fetch_sequencer.sv
// Fetch-side PC sequencer: owns the PC, issues instruction-memory requests with a
// ready handshake, loads IF/ID, and flushes the wrong-path slot on ID redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCSel,
  input  logic [31:0]      BranchPC,
  input  logic             Stall_PC,
  input  logic             IMem_Ready,
  input  logic [31:0]      IMem_Data,
  output logic             IMem_Req,
  output logic [31:0]      IMem_Addr,
  output logic [31:0]      PC,
  output logic [31:0]      IFID_Instruction,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      pcplus4_reg, pcplus4_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [31:0]      pc_inc;

  assign pc_inc = pc_reg + STEP;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      instr_reg     <= '0;
      pcplus4_reg   <= '0;
      valid_reg     <= 1'b0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pcplus4_reg   <= pcplus4_next;
      valid_reg     <= valid_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    pcplus4_next   = pcplus4_reg;
    valid_next     = valid_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      BOOT: begin
        state_next   = RUN;
        instr_next   = '0;
        pcplus4_next = '0;
        valid_next   = 1'b0;
      end
      default: begin
        // A stall freezes everything, including any pending redirect.
        if (!Stall_PC) begin
          if (PCSel) begin
            pc_next      = BranchPC;
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
            state_next   = RUN;
            if (!(&flush_cnt_reg)) flush_cnt_next = flush_cnt_reg + 1'b1;
          end else if (IMem_Ready) begin
            instr_next   = IMem_Data;
            pcplus4_next = pc_inc;
            valid_next   = 1'b1;
            pc_next      = pc_inc;
            state_next   = RUN;
          end else begin
            instr_next   = '0;
            pcplus4_next = '0;
            valid_next   = 1'b0;
            state_next   = WAIT_MEM;
          end
        end
      end
    endcase
  end

  assign IMem_Req         = (state_reg != BOOT);
  assign IMem_Addr        = pc_reg;
  assign PC               = pc_reg;
  assign IFID_Instruction = instr_reg;
  assign IFID_PCPlus4     = pcplus4_reg;
  assign IFID_Valid       = valid_reg;
  assign Flush_Count      = flush_cnt_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer against a behavioural fetch model, with a
// directed prologue pinning the model to hand-computed values.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, pcsel, stall_pc, imem_ready;
  logic [31:0] branch_pc, imem_data, salt;

  logic        imem_req, ifid_valid, imem_req2, ifid_valid2;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pcplus4;
  logic [31:0] imem_addr2, pc2, ifid_instr2, ifid_pcplus42;
  logic [15:0] flush_count;
  logic [1:0]  flush_count2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_p4;
  bit          m_boot, m_valid;
  int          m_flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_data = word_at(imem_addr) ^ salt;

  pc_fetch_sequencer dut (
    .Clk(clk), .Reset(reset), .PCSel(pcsel), .BranchPC(branch_pc), .Stall_PC(stall_pc),
    .IMem_Ready(imem_ready), .IMem_Data(imem_data), .IMem_Req(imem_req),
    .IMem_Addr(imem_addr), .PC(pc), .IFID_Instruction(ifid_instr),
    .IFID_PCPlus4(ifid_pcplus4), .IFID_Valid(ifid_valid), .Flush_Count(flush_count)
  );

  pc_fetch_sequencer #(.CNT_W(2)) dut2 (
    .Clk(clk), .Reset(reset), .PCSel(pcsel), .BranchPC(branch_pc), .Stall_PC(stall_pc),
    .IMem_Ready(imem_ready), .IMem_Data(imem_data), .IMem_Req(imem_req2),
    .IMem_Addr(imem_addr2), .PC(pc2), .IFID_Instruction(ifid_instr2),
    .IFID_PCPlus4(ifid_pcplus42), .IFID_Valid(ifid_valid2), .Flush_Count(flush_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Fetch rules: reset > boot bubble > stall > redirect > accept > wait bubble.
  task automatic model_update();
    if (reset) begin
      m_pc = 32'h0; m_boot = 1; m_instr = 0; m_p4 = 0; m_valid = 0; m_flush = 0;
    end else if (m_boot) begin
      m_boot = 0; m_instr = 0; m_p4 = 0; m_valid = 0;
    end else if (stall_pc) begin
      // frozen
    end else if (pcsel) begin
      m_pc = branch_pc; m_instr = 0; m_p4 = 0; m_valid = 0; m_flush++;
    end else if (imem_ready) begin
      m_instr = word_at(m_pc) ^ salt; m_p4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    end else begin
      m_instr = 0; m_p4 = 0; m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cmp_en = 1;
    #1;
    $display("cyc t=%0t rst=%0b stall=%0b pcsel=%0b bpc=%h rdy=%0b -> pc=%h v=%0b p4=%h fc=%0d",
             $time, reset, stall_pc, pcsel, branch_pc, imem_ready, pc, ifid_valid,
             ifid_pcplus4, flush_count);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", 32'(imem_req), 32'(!m_boot));
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pcplus4", ifid_pcplus4, m_p4);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("flush_count", 32'(flush_count), (m_flush > 65535) ? 32'd65535 : 32'(m_flush));
      chk("flush_count_w2", 32'(flush_count2), (m_flush > 3) ? 32'd3 : 32'(m_flush));
      chk("pc_w2", pc2, m_pc);
    end
  end

  initial begin
    reset = 1; pcsel = 0; stall_pc = 0; imem_ready = 1; branch_pc = 0; salt = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_flush", 32'(flush_count), 32'h0);

    reset = 0;
    step();
    chk("boot_req", 32'(imem_req), 32'h1);
    chk("boot_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("seq_p4_4", ifid_pcplus4, 32'h4);
    chk("seq_instr0", ifid_instr, 32'h0000_FFFF);
    chk("seq_valid", 32'(ifid_valid), 32'h1);
    step(); chk("seq_p4_8", ifid_pcplus4, 32'h8);
    step(); chk("seq_p4_c", ifid_pcplus4, 32'hC);
    step(); chk("seq_pc_10", pc, 32'h10);

    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_pc", pc, 32'h10);
      chk("wait_valid", 32'(ifid_valid), 32'h0);
    end
    imem_ready = 1;
    step();
    chk("wait_done_pc", pc, 32'h14);
    chk("wait_done_instr", ifid_instr, 32'h0010_FFEF);

    for (int i = 0; i < 4; i++) step();
    chk("pre_redir_pc", pc, 32'h24);
    pcsel = 1; branch_pc = 32'h40;
    step();
    chk("redir_pc", pc, 32'h40);
    chk("redir_valid", 32'(ifid_valid), 32'h0);
    chk("redir_flush", 32'(flush_count), 32'h1);
    pcsel = 0;
    step();
    chk("redir_p4", ifid_pcplus4, 32'h44);

    stall_pc = 1; pcsel = 1; branch_pc = 32'h80;
    step(); step();
    chk("stall_pc", pc, 32'h44);
    chk("stall_p4", ifid_pcplus4, 32'h44);
    chk("stall_flush", 32'(flush_count), 32'h1);
    stall_pc = 0;
    step();
    chk("unstall_pc", pc, 32'h80);
    chk("unstall_flush", 32'(flush_count), 32'h2);

    pcsel = 0; imem_ready = 0;
    step();
    pcsel = 1; branch_pc = 32'h100; salt = 32'hDEAD_BEEF;
    step();
    chk("wait_redir_pc", pc, 32'h100);
    chk("wait_redir_valid", 32'(ifid_valid), 32'h0);
    pcsel = 0; imem_ready = 1; salt = 0;
    step();
    chk("wait_redir_p4", ifid_pcplus4, 32'h104);

    pcsel = 1; branch_pc = 32'hFFFF_FFFC;
    step();
    pcsel = 0;
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_p4", ifid_pcplus4, 32'h0);
    chk("wrap_flush", 32'(flush_count), 32'h4);
    chk("sat_flush_w2", 32'(flush_count2), 32'h3);

    imem_ready = 0;
    step();
    reset = 1;
    step();
    chk("midwait_rst_pc", pc, 32'h0);
    chk("midwait_rst_req", 32'(imem_req), 32'h0);
    chk("midwait_rst_flush_w2", 32'(flush_count2), 32'h0);
    reset = 0;

    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      stall_pc   = ($urandom_range(0, 99) < 15);
      pcsel      = ($urandom_range(0, 99) < 20);
      imem_ready = ($urandom_range(0, 99) < 70);
      salt       = $urandom;
      case ($urandom_range(0, 2))
        0:       branch_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        1:       branch_pc = $urandom & 32'h0000_0FFC;
        default: branch_pc = $urandom;
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
